// File: rtl/mem_responder.sv
// Word-addressed data/stack RAM responder: accepts single read/write requests, inserts
// WAIT_STATES extra cycles, then pulses MemReady. Optional feature macro: MEM_BOUNDS_CHECK_EN.
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemWData,
  output logic [DATA_W-1:0] MemRData,
  output logic              MemReady,
  output logic              MemBusy
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic              MemErr
`endif
);

  localparam int AW = $clog2(DEPTH);

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHK = 1'b1;
`else
  localparam bit BOUNDS_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              oob_q, oob_d;
  logic [DATA_W-1:0] rdata_q;
  logic              access;
  logic              mem_we;
  logic              addr_hi;

  logic [DATA_W-1:0] mem [DEPTH];

  // Any address bit at or above log2(DEPTH) marks the request as out of range.
  if (ADDR_W > AW) begin : g_hi
    assign addr_hi = |MemAddr[ADDR_W-1:AW];
  end else begin : g_nohi
    assign addr_hi = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    oob_d   = oob_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (MemRead || MemWrite) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_STATES);
          addr_d  = MemAddr[AW-1:0];
          wdata_d = MemWData;
          wr_d    = MemWrite;
          oob_d   = BOUNDS_CHK & addr_hi;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      oob_q   <= oob_d;
    end
  end

  // Reset on the access edge must still discard the pending write.
  assign mem_we = access && wr_q && !oob_q && !Reset;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Read data is not reset; the output is gated to zero outside RESP instead.
  always_ff @(posedge CLK) begin
    if (access) begin
      rdata_q <= (wr_q || oob_q) ? '0 : mem[addr_q];
    end
  end

  assign MemReady = (state_q == S_RESP);
  assign MemBusy  = (state_q == S_WAIT);
  assign MemRData = MemReady ? rdata_q : '0;

`ifdef MEM_BOUNDS_CHECK_EN
  assign MemErr = MemReady & oob_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: main instance with WAIT_STATES=1, second with WAIT_STATES=0.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd, wr;
  logic [15:0] addr, wdata, rdata;
  logic        ready, busy;
  logic        rd1, wr1;
  logic [15:0] addr1, wdata1, rdata1;
  logic        ready1, busy1;
`ifdef MEM_BOUNDS_CHECK_EN
  logic        err, err1;
`endif

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_STATES(1)) u_dut (
    .CLK(clk), .Reset(rst), .MemRead(rd), .MemWrite(wr), .MemAddr(addr), .MemWData(wdata),
    .MemRData(rdata), .MemReady(ready), .MemBusy(busy)
`ifdef MEM_BOUNDS_CHECK_EN
    , .MemErr(err)
`endif
  );

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .CLK(clk), .Reset(rst), .MemRead(rd1), .MemWrite(wr1), .MemAddr(addr1), .MemWData(wdata1),
    .MemRData(rdata1), .MemReady(ready1), .MemBusy(busy1)
`ifdef MEM_BOUNDS_CHECK_EN
    , .MemErr(err1)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request on the WAIT_STATES=1 instance; reports data/flag at the MemReady cycle.
  task automatic xact(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd_o, output int lat, output logic got,
                      output logic err_o);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    got = 1'b0; lat = 0; rd_o = '0; err_o = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (ready) begin
        got  = 1'b1;
        rd_o = rdata;
`ifdef MEM_BOUNDS_CHECK_EN
        err_o = err;
`endif
        break;
      end
    end
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl[12];
  logic [15:0] got_data;
  int          lat;
  logic        got;
  logic        got_err;
  int          pulses;
  logic [15:0] seen;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 16'h0011, 16'hA5A5, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234};
    tbl[2]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'hA5A5};
    tbl[3]  = '{1'b0, 1'b1, 16'h03FF, 16'hFFFF, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 1'b1, 16'hFFFF};
    tbl[5]  = '{1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001};
    tbl[7]  = '{1'b1, 1'b1, 16'h0007, 16'h00AA, 1'b0, 16'h0000};
    tbl[8]  = '{1'b1, 1'b0, 16'h0007, 16'h0000, 1'b1, 16'h00AA};
    tbl[9]  = '{1'b0, 1'b1, 16'h0010, 16'h0F0F, 1'b0, 16'h0000};
    tbl[10] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0F0F};
    tbl[11] = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 1'b1, 16'hFFFF};

    rst = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", 32'(ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset ready0", 32'(ready1), 32'd0);
    check("reset busy0", 32'(busy1), 32'd0);
`ifdef MEM_BOUNDS_CHECK_EN
    check("reset err", 32'(err), 32'd0);
`endif
    rst = 1'b0;

    // Write timing: busy for the accept edge and the wait edge, then one ready pulse.
    @(negedge clk);
    wr = 1'b1; addr = 16'h0010; wdata = 16'h1234;
    @(posedge clk);
    #1 wr = 1'b0;
    @(negedge clk);
    check("t1 busy e0", 32'({busy, ready}), 32'b10);
    @(negedge clk);
    check("t1 busy e1", 32'({busy, ready}), 32'b10);
    @(negedge clk);
    check("t1 ready e2", 32'({busy, ready}), 32'b01);
    @(negedge clk);
    check("t1 idle e3", 32'({busy, ready}), 32'b00);

    // Strobe during busy must be dropped: one pulse, data of the first request.
    @(negedge clk);
    rd = 1'b1; addr = 16'h0010;
    @(posedge clk);
    #1 rd = 1'b0;
    @(negedge clk);
    rd = 1'b1; addr = 16'h0011;
    @(posedge clk);
    #1 rd = 1'b0;
    pulses = 0;
    seen   = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        seen = rdata;
      end
    end
    check("t3 pulses", 32'(pulses), 32'd1);
    check("t3 rdata", 32'(seen), 32'h1234);

    for (int i = 0; i < 12; i++) begin
      xact(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, got_data, lat, got, got_err);
      check($sformatf("vec%0d ready", i), 32'(got), 32'd1);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      if (tbl[i].chk) check($sformatf("vec%0d rdata", i), 32'(got_data), 32'(tbl[i].exp));
`ifdef MEM_BOUNDS_CHECK_EN
      check($sformatf("vec%0d err", i), 32'(got_err), 32'd0);
`endif
    end

    // Reset landing on the access edge of a write aborts it.
    xact(1'b0, 1'b1, 16'h0009, 16'h1111, got_data, lat, got, got_err);
    @(negedge clk);
    wr = 1'b1; addr = 16'h0009; wdata = 16'h5555;
    @(posedge clk);
    #1 wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5 busy pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5 outs", 32'({busy, ready, rdata}), 32'd0);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("t5 no ready", 32'(pulses), 32'd0);
    xact(1'b1, 1'b0, 16'h0009, 16'h0000, got_data, lat, got, got_err);
    check("t5 read9", 32'(got_data), 32'h1111);

    // Address at DEPTH: flagged and suppressed with the check, wrapped to 0 without it.
    xact(1'b0, 1'b1, 16'h0000, 16'h2222, got_data, lat, got, got_err);
    xact(1'b0, 1'b1, 16'h0400, 16'h7777, got_data, lat, got, got_err);
    check("t6 ready", 32'(got), 32'd1);
`ifdef MEM_BOUNDS_CHECK_EN
    check("t6 err", 32'(got_err), 32'd1);
    xact(1'b1, 1'b0, 16'h0000, 16'h0000, got_data, lat, got, got_err);
    check("t6 read0", 32'(got_data), 32'h2222);
    check("t6 read0 err", 32'(got_err), 32'd0);
    xact(1'b1, 1'b0, 16'h0400, 16'h0000, got_data, lat, got, got_err);
    check("t6 oob rdata", 32'(got_data), 32'd0);
    check("t6 oob rd err", 32'(got_err), 32'd1);
`else
    xact(1'b1, 1'b0, 16'h0000, 16'h0000, got_data, lat, got, got_err);
    check("t6 read0", 32'(got_data), 32'h7777);
`endif

    // Zero wait states: read issued in the write's RESP cycle is accepted back-to-back.
    @(negedge clk);
    wr1 = 1'b1; addr1 = 16'h0005; wdata1 = 16'hBEEF;
    @(posedge clk);
    #1 wr1 = 1'b0;
    @(negedge clk);
    check("t2 busy e0", 32'({busy1, ready1}), 32'b10);
    @(negedge clk);
    check("t2 wr ready", 32'({busy1, ready1}), 32'b01);
    rd1 = 1'b1; addr1 = 16'h0005;
    @(posedge clk);
    #1 rd1 = 1'b0;
    @(negedge clk);
    check("t2 rd busy", 32'({busy1, ready1}), 32'b10);
    @(negedge clk);
    check("t2 rd ready", 32'(ready1), 32'd1);
    check("t2 rdata", 32'(rdata1), 32'hBEEF);
    @(negedge clk);
    check("t2 idle", 32'({busy1, ready1, rdata1}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
